// File: rtl/gf2_mul_serial_if.sv
// Handshake and data bundle for the bit-serial GF(2^N) multiplier.
// master drives the request side; slave is the multiplier itself.
interface gf2_mul_serial_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] poly_in;
    logic         ready;
    logic         busy;
    logic         out_valid;
    logic [N-1:0] result;

    modport master (
        output start, a_in, b_in, poly_in,
        input  ready, busy, out_valid, result
    );

    modport slave (
        input  start, a_in, b_in, poly_in,
        output ready, busy, out_valid, result
    );
endinterface

// File: rtl/gf2_mul_serial.sv
// Bit-serial LSB-first GF(2^N) multiplier, result = a*b mod (x^N + poly).
// Optional early termination on exhausted multiplier: GF2_MUL_FASTEXIT_EN.
module gf2_mul_serial #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             reset,
    gf2_mul_serial_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  a_reg, a_n;
    logic [N-1:0]  b_reg, b_n;
    logic [N-1:0]  p_reg, p_n;
    logic [N-1:0]  acc, acc_n;
    logic [N-1:0]  res, res_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [N-1:0]  acc_x;
    logic [N-1:0]  a_x;
    logic [N-1:0]  b_x;
    logic          last;

    // One step of the shift-and-add: accumulate, then a := a*x mod p.
    always_comb begin
        acc_x = b_reg[0] ? (acc ^ a_reg) : acc;
        a_x   = {a_reg[N-2:0], 1'b0} ^ (a_reg[N-1] ? p_reg : '0);
        b_x   = b_reg >> 1;
`ifdef GF2_MUL_FASTEXIT_EN
        last  = (cnt == CW'(N - 1)) || (b_x == '0);
`else
        last  = (cnt == CW'(N - 1));
`endif
    end

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        p_n     = p_reg;
        acc_n   = acc;
        res_n   = res;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a_in;
                    b_n     = bus.b_in;
                    p_n     = bus.poly_in;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = S_RUN;
`ifdef GF2_MUL_FASTEXIT_EN
                    if (bus.b_in == '0) begin
                        res_n   = '0;
                        state_n = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_n = acc_x;
                a_n   = a_x;
                b_n   = b_x;
                cnt_n = cnt + CW'(1);
                if (last) begin
                    res_n   = acc_x;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
            acc   <= '0;
            res   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            a_reg <= a_n;
            b_reg <= b_n;
            p_reg <= p_n;
            acc   <= acc_n;
            res   <= res_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.busy      = (state == S_RUN);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = res;

endmodule

// File: tb/tb_gf2_mul_serial.sv
// Randomized bench for gf2_mul_serial at N=8 and N=32 against a
// polynomial long-division reference model.
module tb_gf2_mul_serial;
    logic clk;
    logic reset;

    gf2_mul_serial_if #(.N(8))  i8 ();
    gf2_mul_serial_if #(.N(32)) i32 ();

    gf2_mul_serial #(.N(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (i8)
    );

    gf2_mul_serial #(.N(32)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (i32)
    );

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full carry-less product, then reduce by x^n + p via long division.
    function automatic logic [63:0] gf_ref(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [63:0] p,
                                           input int n);
        logic [127:0] prod;
        logic [127:0] m;
        logic [127:0] msk;
        msk  = (128'(1) << n) - 128'(1);
        prod = '0;
        for (int i = 0; i < n; i++)
            if (b[i]) prod = prod ^ ((128'(a) & msk) << i);
        m = (128'(1) << n) | (128'(p) & msk);
        for (int i = 2 * n - 2; i >= n; i--)
            if (prod[i]) prod = prod ^ (m << (i - n));
        return 64'(prod & msk);
    endfunction

    function automatic int exp_lat(input logic [63:0] b, input int n);
`ifdef GF2_MUL_FASTEXIT_EN
        int h;
        h = -1;
        for (int i = 0; i < n; i++)
            if (b[i]) h = i;
        return h + 1;
`else
        return n + 0 * int'(b[0]);
`endif
    endfunction

    function automatic logic rdy(input bit w);
        return w ? i32.ready : i8.ready;
    endfunction

    function automatic logic bsy(input bit w);
        return w ? i32.busy : i8.busy;
    endfunction

    function automatic logic ov(input bit w);
        return w ? i32.out_valid : i8.out_valid;
    endfunction

    function automatic logic [63:0] res(input bit w);
        return w ? 64'(i32.result) : 64'(i8.result);
    endfunction

    task automatic drive(input bit w, input logic st,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p);
        if (w) begin
            i32.start   = st;
            i32.a_in    = a;
            i32.b_in    = b;
            i32.poly_in = p;
        end else begin
            i8.start   = st;
            i8.a_in    = a[7:0];
            i8.b_in    = b[7:0];
            i8.poly_in = p[7:0];
        end
    endtask

    task automatic run_op(input bit w, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p,
                          input string tag);
        int          n;
        int          lat;
        logic [63:0] e;
        logic [63:0] bm;
        n  = w ? 32 : 8;
        bm = w ? 64'(b) : 64'(b[7:0]);
        e  = gf_ref(64'(a), bm, 64'(p), n);
        @(negedge clk);
        chk({tag, "_ready_in"}, 64'(rdy(w)), 64'd1);
        drive(w, 1'b1, a, b, p);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 32'h0, 32'h0, 32'h0);
        lat = 0;
        forever begin
            @(negedge clk);
            if (ov(w)) break;
            chk({tag, "_run_rb"}, {62'd0, rdy(w), bsy(w)}, 64'd1);
            lat++;
            if (lat > 100) begin
                chk({tag, "_timeout"}, 64'd1, 64'd0);
                break;
            end
        end
        chk({tag, "_result"}, res(w), e);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(bm, n)));
        chk({tag, "_done_rb"}, {62'd0, rdy(w), bsy(w)}, 64'd0);
        @(negedge clk);
        chk({tag, "_ov_pulse"}, 64'(ov(w)), 64'd0);
        chk({tag, "_idle"}, 64'(rdy(w)), 64'd1);
        chk({tag, "_hold"}, res(w), e);
    endtask

    task automatic hold_start_test();
        logic [63:0] q[$];
        logic [63:0] last;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          pend;
        int          ops;
        int          pulses;
        pend   = 0;
        ops    = 0;
        pulses = 0;
        @(negedge clk);
        last = res(0);
        for (int c = 0; c < 140; c++) begin
            if (c > 0) @(negedge clk);
            if (pend) chk("hs_ready_low", 64'(i8.ready), 64'd0);
            if (i8.out_valid) begin
                pulses++;
                if (q.size() == 0) chk("hs_extra_pulse", 64'd1, 64'd0);
                else chk("hs_result", res(0), q.pop_front());
                last = res(0);
                pend = 0;
            end else begin
                chk("hs_hold", res(0), last);
            end
            a = 8'($urandom);
            b = (c % 7 == 3) ? 8'h00 : 8'($urandom);
            if (c < 120) drive(0, 1'b1, 32'(a), 32'(b), 32'h1B);
            else drive(0, 1'b0, 32'h0, 32'h0, 32'h0);
            if (i8.ready && c < 120) begin
                q.push_back(gf_ref(64'(a), 64'(b), 64'h1B, 8));
                pend = 1;
                ops++;
            end
        end
        chk("hs_pulses", 64'(pulses), 64'(ops));
        chk("hs_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic reset_test();
        run_op(0, 32'h57, 32'h83, 32'h1B, "rs_pre");
        @(negedge clk);
        drive(0, 1'b1, 32'h57, 32'h83, 32'h1B);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_ready", 64'(i8.ready), 64'd1);
        chk("rs_busy", 64'(i8.busy), 64'd0);
        chk("rs_result", res(0), 64'd0);
        chk("rs_ov", 64'(i8.out_valid), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rs_no_ov", 64'(i8.out_valid), 64'd0);
        end
        run_op(0, 32'h57, 32'h83, 32'h1B, "rs_post");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst8_ready", 64'(i8.ready), 64'd1);
        chk("rst8_busy", 64'(i8.busy), 64'd0);
        chk("rst8_ov", 64'(i8.out_valid), 64'd0);
        chk("rst8_result", res(0), 64'd0);
        chk("rst32_ready", 64'(i32.ready), 64'd1);
        chk("rst32_result", res(1), 64'd0);

        run_op(0, 32'h57, 32'h83, 32'h1B, "d_57x83");
        chk("d_57x83_const", res(0), 64'hC1);
        run_op(0, 32'h57, 32'h13, 32'h1B, "d_57x13");
        chk("d_57x13_const", res(0), 64'hFE);
        run_op(0, 32'hA5, 32'h01, 32'h1B, "d_a5x01");
        chk("d_a5x01_const", res(0), 64'hA5);
        run_op(0, 32'hA5, 32'h00, 32'h1B, "d_a5x00");
        chk("d_a5x00_const", res(0), 64'h00);
        run_op(0, 32'hFF, 32'hFF, 32'h00, "d_nored");
        run_op(0, 32'hFF, 32'h80, 32'hFF, "d_maxp");
        run_op(1, 32'h80000000, 32'h2, 32'h8D, "d32_red");
        chk("d32_red_const", res(1), 64'h8D);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] b;
            b = (i % 5 == 0) ? ($urandom & 32'h0F) : $urandom;
            run_op(0, $urandom, b, $urandom, "r8");
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] b;
            b = (i % 3 == 0) ? ($urandom >> (i + 8)) : $urandom;
            run_op(1, $urandom, b, $urandom, "r32");
        end

        hold_start_test();
        reset_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
